sarray_mem_resp: RTL and testbench

//   Memory-side responder for the systolic-array load/store channels (ar/r read, aw write-with-data).

---
 rtl/sarray_mem_resp.sv | 134 +++++++++++++
 tb/tb_sarray_mem_resp.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sarray_mem_resp.sv
// Memory-side responder for the systolic-array load/store channels.
// Line-addressed SRAM model with fixed-latency in-order reads, a credit limit on outstanding reads, and single-beat writes.
module sarray_mem_resp #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned LINE_SHIFT = 8,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned MAX_OUT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ar_valid_i,
    output logic              ar_ready_o,
    input  logic [ADDR_W-1:0] ar_addr_i,
    output logic              r_valid_o,
    input  logic              r_ready_i,
    output logic [DATA_W-1:0] r_data_o,
    input  logic              aw_valid_i,
    output logic              aw_ready_o,
    input  logic [ADDR_W-1:0] aw_addr_i,
    input  logic [DATA_W-1:0] aw_data_i
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] fifo_q [MAX_OUT];

    logic              ar_ready_q;
    logic              aw_ready_q;
    logic              r_valid_q;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]  fcnt_q, fcnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;

    logic [IDX_W-1:0]  ar_idx_c, aw_idx_c;
    logic              ar_hsk_c, aw_hsk_c, r_hsk_c;
    logic              push_c;
    logic [DATA_W-1:0] push_data_c;
    logic              unused_addr_bits;

    assign ar_idx_c = ar_addr_i[LINE_SHIFT +: IDX_W];
    assign aw_idx_c = aw_addr_i[LINE_SHIFT +: IDX_W];
    assign unused_addr_bits = ^{ar_addr_i[ADDR_W-1:LINE_SHIFT+IDX_W], ar_addr_i[LINE_SHIFT-1:0],
                                aw_addr_i[ADDR_W-1:LINE_SHIFT+IDX_W], aw_addr_i[LINE_SHIFT-1:0]};

    // Handshakes are suppressed while reset is asserted so nothing is accepted or written.
    assign ar_hsk_c = ar_valid_i & ar_ready_q & ~rst;
    assign aw_hsk_c = aw_valid_i & aw_ready_q & ~rst;
    assign r_hsk_c  = r_valid_q & r_ready_i;

    assign ar_ready_o = ar_ready_q;
    assign aw_ready_o = aw_ready_q;
    assign r_valid_o  = r_valid_q;
    assign r_data_o   = fifo_q[rd_ptr_q];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (aw_hsk_c) mem[aw_idx_c] <= aw_data_i;
    end

    // Read sampled at the AR edge gives read-before-write on a same-cycle collision.
    generate
        if (RD_LAT == 1) begin : g_direct
            assign push_c      = ar_hsk_c;
            assign push_data_c = mem[ar_idx_c];
        end else begin : g_pipe
            localparam int unsigned NSTG = RD_LAT - 1;
            logic [NSTG-1:0]   pv_q;
            logic [DATA_W-1:0] pd_q [NSTG];

            always_ff @(posedge clk) begin
                if (rst) begin
                    pv_q <= '0;
                end else begin
                    pv_q[0] <= ar_hsk_c;
                    for (int i = 1; i < int'(NSTG); i++) pv_q[i] <= pv_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (ar_hsk_c) pd_q[0] <= mem[ar_idx_c];
                for (int i = 1; i < int'(NSTG); i++) pd_q[i] <= pd_q[i-1];
            end

            assign push_c      = pv_q[NSTG-1];
            assign push_data_c = pd_q[NSTG-1];
        end
    endgenerate

    // Credit and return-FIFO occupancy for the next cycle.
    always_comb begin
        out_cnt_d = out_cnt_q;
        fcnt_d    = fcnt_q;
        if (ar_hsk_c) out_cnt_d = out_cnt_d + CNT_W'(1);
        if (r_hsk_c)  out_cnt_d = out_cnt_d - CNT_W'(1);
        if (push_c)   fcnt_d    = fcnt_d + CNT_W'(1);
        if (r_hsk_c)  fcnt_d    = fcnt_d - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_ready_q <= 1'b1;
            aw_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            out_cnt_q  <= '0;
            fcnt_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < int'(MAX_OUT); i++) fifo_q[i] <= '0;
        end else begin
            ar_ready_q <= (out_cnt_d < CNT_W'(MAX_OUT));
            aw_ready_q <= 1'b1;
            r_valid_q  <= (fcnt_d != '0);
            out_cnt_q  <= out_cnt_d;
            fcnt_q     <= fcnt_d;
            if (push_c) begin
                fifo_q[wr_ptr_q] <= push_data_c;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (r_hsk_c) rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_c && (fcnt_q == CNT_W'(MAX_OUT)) && !r_hsk_c));

endmodule

// File: tb/tb_sarray_mem_resp.sv
// Scoreboard bench for sarray_mem_resp: a bench-side memory model predicts every read beat at AR time.
module tb_sarray_mem_resp;
    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned DATA_W     = 256;
    localparam int unsigned LINE_SHIFT = 8;
    localparam int unsigned DEPTH      = 1024;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned MAX_OUT    = 4;
    localparam int unsigned IDX_W      = $clog2(DEPTH);

    logic              clk;
    logic              rst;
    logic              ar_valid_i;
    logic              ar_ready_o;
    logic [ADDR_W-1:0] ar_addr_i;
    logic              r_valid_o;
    logic              r_ready_i;
    logic [DATA_W-1:0] r_data_o;
    logic              aw_valid_i;
    logic              aw_ready_o;
    logic [ADDR_W-1:0] aw_addr_i;
    logic [DATA_W-1:0] aw_data_i;

    sarray_mem_resp #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_SHIFT(LINE_SHIFT),
        .DEPTH(DEPTH), .RD_LAT(RD_LAT), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
        .aw_data_i(aw_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] got_q [$];
    int checks = 0;
    int errors = 0;
    int out_m = 0;
    int ar_acc = 0;
    int beats = 0;
    int cyc = 0;
    int first_beat = -1;
    int last_beat = -1;
    bit armed = 1'b0;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [IDX_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        return a[LINE_SHIFT +: IDX_W];
    endfunction

    function automatic logic [DATA_W-1:0] pat(input int i);
        logic [31:0] w;
        w = (32'(i) * 32'h9E3779B1) ^ 32'h13572468;
        return {8{w}};
    endfunction

    // Monitor: compares outputs with the model, then applies the handshakes of the coming edge.
    always @(negedge clk) begin
        logic [DATA_W-1:0] e;
        cyc++;
        if (armed) begin
            check_eq("ar_ready", DATA_W'(ar_ready_o), DATA_W'(out_m < int'(MAX_OUT)));
            check_eq("aw_ready", DATA_W'(aw_ready_o), DATA_W'(1));
            check_eq("spurious_r", DATA_W'(r_valid_o && exp_q.size() == 0), DATA_W'(0));
            if (rst) begin
                exp_q.delete();
                out_m = 0;
            end else begin
                if (r_valid_o && r_ready_i && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("r_data", r_data_o, e);
                    got_q.push_back(r_data_o);
                    out_m--;
                    beats++;
                    if (first_beat < 0) first_beat = cyc;
                    last_beat = cyc;
                end
                if (ar_valid_i && ar_ready_o) begin
                    exp_q.push_back(model[line_of(ar_addr_i)]);
                    out_m++;
                    ar_acc++;
                end
                if (aw_valid_i && aw_ready_o) model[line_of(aw_addr_i)] = aw_data_i;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (exp_q.size() > 0 || r_valid_o); k++) tick();
        check_eq("drain", DATA_W'(exp_q.size() == 0 && !r_valid_o), DATA_W'(1));
    endtask

    task automatic read_one(input logic [ADDR_W-1:0] a);
        ar_valid_i = 1'b1;
        ar_addr_i  = a;
        tick();
        ar_valid_i = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] w1;
        logic [ADDR_W-1:0] wrap_a;
        rst = 1'b1; ar_valid_i = 1'b0; ar_addr_i = '0; r_ready_i = 1'b0;
        aw_valid_i = 1'b0; aw_addr_i = '0; aw_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        armed = 1'b1;

        // Preload every line with a known pattern.
        aw_valid_i = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            aw_addr_i = ADDR_W'(i) << LINE_SHIFT;
            aw_data_i = pat(i);
            tick();
        end
        aw_valid_i = 1'b0;

        // Reset held two cycles with AR/AW valid: nothing accepted, memory untouched.
        aw_valid_i = 1'b1; aw_addr_i = 64'h500; aw_data_i = '1;
        ar_valid_i = 1'b1; ar_addr_i = 64'h500;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check_eq("rst_ar_ready", DATA_W'(ar_ready_o), DATA_W'(1));
            check_eq("rst_r_valid", DATA_W'(r_valid_o), DATA_W'(0));
            check_eq("rst_r_data", r_data_o, '0);
        end
        rst = 1'b0; ar_valid_i = 1'b0; aw_valid_i = 1'b0;
        r_ready_i = 1'b1;
        got_q.delete();
        read_one(64'h500);
        drain();
        check_eq("rst_no_write", got_q.size() > 0 ? got_q[0] : '0, pat(5));

        // Write then read: latency and data.
        aw_valid_i = 1'b1; aw_addr_i = 64'h100; aw_data_i = {32{8'hA5}};
        tick();
        aw_valid_i = 1'b0;
        read_one(64'h100);
        check_eq("lat_early", DATA_W'(r_valid_o), DATA_W'(0));
        tick();
        check_eq("lat_valid", DATA_W'(r_valid_o), DATA_W'(1));
        check_eq("wr_rd_data", r_data_o, {32{8'hA5}});
        tick();
        check_eq("lat_popped", DATA_W'(r_valid_o), DATA_W'(0));

        // Credits under backpressure: 6 back-to-back ARs, only MAX_OUT accepted.
        r_ready_i = 1'b0;
        ar_acc = 0;
        for (int i = 0; i < 6; i++) read_one(ADDR_W'(i) << LINE_SHIFT);
        check_eq("credit_acc", DATA_W'(ar_acc), DATA_W'(MAX_OUT));
        check_eq("credit_stall", DATA_W'(ar_ready_o), DATA_W'(0));
        repeat (3) tick();
        check_eq("hold_valid", DATA_W'(r_valid_o), DATA_W'(1));
        check_eq("hold_data", r_data_o, pat(0));
        r_ready_i = 1'b1;
        drain();
        check_eq("credit_back", DATA_W'(ar_ready_o), DATA_W'(1));

        // Streaming: 64 ARs every cycle, one beat per cycle, no bubbles.
        ar_acc = 0; beats = 0; first_beat = -1;
        ar_valid_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            ar_addr_i = ADDR_W'(i) << LINE_SHIFT;
            tick();
        end
        ar_valid_i = 1'b0;
        drain();
        check_eq("stream_acc", DATA_W'(ar_acc), DATA_W'(64));
        check_eq("stream_beats", DATA_W'(beats), DATA_W'(64));
        check_eq("stream_span", DATA_W'(last_beat - first_beat), DATA_W'(63));

        // Same-cycle AR+AW collision returns old data; a later read sees the new data.
        y = {8{32'hDEADBEEF}};
        got_q.delete();
        ar_valid_i = 1'b1; ar_addr_i = 64'h300;
        aw_valid_i = 1'b1; aw_addr_i = 64'h300; aw_data_i = y;
        tick();
        aw_valid_i = 1'b0;
        tick();
        ar_valid_i = 1'b0;
        drain();
        check_eq("collide_old", got_q.size() > 0 ? got_q[0] : '0, pat(3));
        check_eq("collide_new", got_q.size() > 1 ? got_q[1] : '0, y);

        // Reset mid-burst drops in-flight reads and clears credits.
        r_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) read_one(ADDR_W'(i + 8) << LINE_SHIFT);
        repeat (3) tick();
        check_eq("pre_rst_valid", DATA_W'(r_valid_o), DATA_W'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_r_data", r_data_o, '0);
        for (int k = 0; k < 4; k++) begin
            check_eq("mid_rst_no_beat", DATA_W'(r_valid_o), DATA_W'(0));
            tick();
        end
        ar_acc = 0;
        for (int i = 0; i < 5; i++) read_one(ADDR_W'(i + 16) << LINE_SHIFT);
        check_eq("rst_credits", DATA_W'(ar_acc), DATA_W'(MAX_OUT));
        r_ready_i = 1'b1;
        drain();

        // Address wrap: bits above the index and below the line are ignored.
        w1 = {8{32'h0123ABCD}};
        wrap_a = (ADDR_W'(DEPTH) << LINE_SHIFT) + 64'h100;
        aw_valid_i = 1'b1; aw_addr_i = wrap_a; aw_data_i = w1;
        tick();
        aw_valid_i = 1'b0;
        got_q.delete();
        read_one(64'h100);
        read_one(wrap_a);
        read_one(64'hFFFF_0000_0000_017F);
        drain();
        for (int i = 0; i < 3; i++)
            check_eq("wrap", got_q.size() > i ? got_q[i] : '0, w1);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
